mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency main memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each memory transaction, returns read data with a one-cycle acknowledge, and raises per-requester stall flags for the hazard unit.
- Data port has priority. A bounded anti-starvation counter guarantees forward progress of fetch.

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// (read-only) and the load/store data port. Each transaction is one MemEn
// cycle followed by MEM_LAT wait cycles; read data is returned with a
// one-cycle acknowledge. Data has priority, bounded by a starvation counter
// that eventually forces a waiting fetch through.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [31:0]   IRData,
    output logic          IAck,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [31:0]   DWData,
    output logic [31:0]   DRData,
    output logic          DAck,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [31:0]   MemWData,
    input  logic [31:0]   MemRData,
    output logic          StallI,
    output logic          StallDm,
    output logic          Busy,
    output logic          Owner
);

    // The starve counter needs at least one bit even when forcing is disabled.
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]    LAT_LOAD   = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_iack;
    logic            r_dack;
    logic [31:0]     r_irdata;
    logic [31:0]     r_drdata;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic            r_owner;
    logic            r_is_store;
    logic [SW-1:0]   r_starve;
    logic [3:0]      r_lat;

    logic            w_i_elig;
    logic            w_d_elig;
    logic            w_force_i;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_done;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decision; a port whose Ack is high this cycle is
    // still holding the request just served, so it cannot be granted again.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_i_elig    = IReq & ~r_iack;
        w_d_elig    = DReq & ~r_dack;
        w_force_i   = (STARVE_LIMIT != 0) && (r_starve == STARVE_MAX);
        case (r_state)
            S_IDLE: begin
                w_grant_i = w_i_elig & (~w_d_elig | w_force_i);
                w_grant_d = w_d_elig & ~w_grant_i;
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_lat == 4'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control: memory strobes, acknowledges, owner, starvation and latency counters.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_iack   <= 1'b0;
            r_dack   <= 1'b0;
            r_owner  <= 1'b0;
            r_starve <= '0;
            r_lat    <= 4'd0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_iack   <= 1'b0;
            r_dack   <= 1'b0;
            if (w_grant_i || w_grant_d) begin
                r_owner  <= w_grant_d;
                r_mem_en <= 1'b1;
                r_mem_we <= w_grant_d & DWe;
            end
            if (w_grant_i) begin
                r_starve <= '0;
            end else if (w_grant_d && IReq && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
            if (r_state == S_ISSUE) begin
                r_lat <= LAT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_lat <= r_lat - 4'd1;
            end
            if (w_done) begin
                r_iack <= ~r_owner;
                r_dack <= r_owner;
            end
        end
    end

    // Datapath: latch the granted request and capture read data on completion.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_is_store  <= 1'b0;
            r_irdata    <= 32'd0;
            r_drdata    <= 32'd0;
        end else begin
            if (w_grant_i) begin
                r_mem_addr <= IAddr;
                r_is_store <= 1'b0;
            end else if (w_grant_d) begin
                r_mem_addr  <= DAddr;
                r_mem_wdata <= DWData;
                r_is_store  <= DWe;
            end
            if (w_done) begin
                if (!r_owner) begin
                    r_irdata <= MemRData;
                end else if (!r_is_store) begin
                    r_drdata <= MemRData;
                end
            end
        end
    end

    assign IRData   = r_irdata;
    assign IAck     = r_iack;
    assign DRData   = r_drdata;
    assign DAck     = r_dack;
    assign MemEn    = r_mem_en;
    assign MemWe    = r_mem_we;
    assign MemAddr  = r_mem_addr;
    assign MemWData = r_mem_wdata;
    assign StallI   = IReq & ~r_iack;
    assign StallDm  = DReq & ~r_dack;
    assign Busy     = (r_state != S_IDLE);
    assign Owner    = r_owner;

    // Requesters must hold their address while a request is outstanding.
    a_iaddr_stable: assert property (@(posedge Clk) disable iff (!Rst_n)
        (IReq && !IAck && $past(IReq && !IAck)) |-> $stable(IAddr));
    a_daddr_stable: assert property (@(posedge Clk) disable iff (!Rst_n)
        (DReq && !DAck && $past(DReq && !DAck)) |-> $stable(DAddr));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random fetch/data request streams against a
// transaction-level model of the arbiter and a behavioural fixed-latency memory.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int LAT  = 3;
    localparam int SL   = 2;
    localparam int NCYC = 3000;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          IReq;
    logic [AW-1:0] IAddr;
    logic [31:0]   IRData;
    logic          IAck;
    logic          DReq;
    logic          DWe;
    logic [AW-1:0] DAddr;
    logic [31:0]   DWData;
    logic [31:0]   DRData;
    logic          DAck;
    logic          MemEn;
    logic          MemWe;
    logic [AW-1:0] MemAddr;
    logic [31:0]   MemWData;
    logic [31:0]   MemRData;
    logic          StallI;
    logic          StallDm;
    logic          Busy;
    logic          Owner;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT), .STARVE_LIMIT(SL)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IReq(IReq), .IAddr(IAddr), .IRData(IRData), .IAck(IAck),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DRData(DRData), .DAck(DAck),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData),
        .StallI(StallI), .StallDm(StallDm), .Busy(Busy), .Owner(Owner)
    );

    // Behavioural memory: 16 words stored as a delta against a per-word salt,
    // read data valid exactly LAT cycles after the MemEn cycle, noise otherwise.
    function automatic logic [31:0] salt(input logic [3:0] i);
        return 32'h5A5A_0000 | (32'(i) * 32'd7919);
    endfunction

    logic [31:0] mem [16] = '{default: 32'd0};
    logic [31:0] pd  [LAT] = '{default: 32'd0};
    logic        pv  [LAT] = '{default: 1'b0};
    logic [31:0] noise = 32'h0BAD_F00D;

    always @(posedge Clk) begin
        pv[0] <= MemEn && !MemWe;
        pd[0] <= mem[MemAddr[3:0]] ^ salt(MemAddr[3:0]);
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        if (MemEn && MemWe) mem[MemAddr[3:0]] <= MemWData ^ salt(MemAddr[3:0]);
        noise <= $urandom;
    end

    assign MemRData = pv[LAT-1] ? pd[LAT-1] : noise;

    // Checking.
    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transaction-level model: a granted transaction occupies phases 0..LAT
    // (phase 0 is the MemEn cycle); the cycle after phase LAT carries the Ack.
    logic [31:0] mm [16];
    bit          m_busy, m_own, m_we, m_iack, m_dack, m_rst_now;
    int          m_phase, m_starve;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;

    task automatic model_reset();
        m_busy = 0; m_phase = 0; m_own = 0; m_we = 0;
        m_iack = 0; m_dack = 0; m_irdata = 32'd0; m_drdata = 32'd0;
        m_starve = 0; m_addr = 32'd0; m_wdata = 32'd0;
    endtask

    task automatic model_step();
        bit iel, del, gi;
        m_rst_now = 0;
        if (!Rst_n) begin
            model_reset();
            m_rst_now = 1;
            return;
        end
        if (m_busy) begin
            if (m_phase == LAT) begin
                m_busy = 0;
                if (!m_own) begin
                    m_iack   = 1;
                    m_irdata = mm[m_addr[3:0]];
                end else begin
                    m_dack = 1;
                    if (!m_we) m_drdata = mm[m_addr[3:0]];
                end
            end else begin
                m_phase++;
            end
        end else begin
            iel    = IReq && !m_iack;
            del    = DReq && !m_dack;
            m_iack = 0;
            m_dack = 0;
            if (iel || del) begin
                gi      = iel && (!del || (SL != 0 && m_starve == SL));
                m_busy  = 1;
                m_phase = 0;
                m_own   = !gi;
                if (gi) begin
                    m_addr   = IAddr;
                    m_we     = 0;
                    m_starve = 0;
                end else begin
                    m_addr  = DAddr;
                    m_we    = DWe;
                    m_wdata = DWData;
                    if (IReq && m_starve < SL) m_starve++;
                    if (DWe) mm[DAddr[3:0]] = DWData;
                end
            end
        end
    endtask

    function automatic logic [31:0] new_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a[31:28] = 4'hC;
        return a;
    endfunction

    // Requester behaviour: hold until Ack, then drop or re-present.
    task automatic drive_inputs(input int c);
        bit allow_i, allow_d;
        int p;
        allow_i = !(c >= 200 && c < 400);
        allow_d = (c >= 200);
        p       = (c >= 400 && c < 1400) ? 70 : 30;
        Rst_n   = !(c < 2 || (c >= 1400 && $urandom_range(0, 149) == 0));
        if (IReq) begin
            if (m_iack) begin
                if ($urandom_range(0, 1) == 1) IReq = 1'b0;
                else if ($urandom_range(0, 1) == 1) IAddr = new_addr();
            end
        end else if (allow_i && $urandom_range(0, 99) < p) begin
            IReq  = 1'b1;
            IAddr = new_addr();
        end
        if (DReq) begin
            if (m_dack) begin
                if ($urandom_range(0, 1) == 1) DReq = 1'b0;
                else if ($urandom_range(0, 1) == 1) begin
                    DAddr  = new_addr();
                    DWe    = 1'($urandom_range(0, 1));
                    DWData = $urandom;
                end
            end
        end else if (allow_d && $urandom_range(0, 99) < p) begin
            DReq   = 1'b1;
            DAddr  = new_addr();
            DWe    = 1'($urandom_range(0, 1));
            DWData = $urandom;
        end
    endtask

    task automatic check_outputs();
        bit exp_en;
        exp_en = m_busy && (m_phase == 0);
        chk("MemEn",   32'(MemEn),   32'(exp_en));
        chk("MemWe",   32'(MemWe),   32'(exp_en && m_we));
        if (exp_en) chk("MemAddr", MemAddr, m_addr);
        if (exp_en && m_we) chk("MemWData", MemWData, m_wdata);
        chk("Busy",    32'(Busy),    32'(m_busy));
        chk("Owner",   32'(Owner),   32'(m_own));
        chk("IAck",    32'(IAck),    32'(m_iack));
        chk("DAck",    32'(DAck),    32'(m_dack));
        chk("IRData",  IRData,       m_irdata);
        chk("DRData",  DRData,       m_drdata);
        chk("StallI",  32'(StallI),  32'(IReq && !m_iack));
        chk("StallDm", 32'(StallDm), 32'(DReq && !m_dack));
        if (m_rst_now) begin
            chk("RstMemAddr",  MemAddr,  32'd0);
            chk("RstMemWData", MemWData, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mm[i] = salt(4'(i));
        model_reset();
        m_rst_now = 0;
        Rst_n  = 1'b0;
        IReq   = 1'b0;
        IAddr  = '0;
        DReq   = 1'b0;
        DWe    = 1'b0;
        DAddr  = '0;
        DWData = 32'd0;
        for (int c = 0; c < NCYC; c++) begin
            cyc = c;
            drive_inputs(c);
            #1;
            if (c > 0) check_outputs();
            model_step();
            @(posedge Clk);
            #1;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
